// File: rtl/seg7_frame_streamer.sv
// Renders DIGITS seven-segment glyphs (16x32 px each) into SSD1306 page-column
// bytes and streams one frame over a valid/ready byte interface.
module seg7_frame_streamer #(
    parameter int DIGITS = 4,
    parameter int SPACE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7*DIGITS-1:0]   segments_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  invert_in,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_page_first,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int CELL_W = SPACE + 16;
    localparam int CW     = $clog2(CELL_W);
    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(CELL_W - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

    state_t                state_q;
    logic [1:0]            page_q;
    logic [DW-1:0]         digit_q;
    logic [CW-1:0]         col_q;
    logic [7*DIGITS-1:0]   segs_q;
    logic [DIGITS-1:0]     blank_q;
    logic                  invert_q;
    logic [7:0]            out_data_q;
    logic                  out_valid_q;
    logic                  page_first_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [1:0]            page_d;
    logic [DW-1:0]         digit_d;
    logic [CW-1:0]         col_d;
    logic [7:0]            byte_d;
    logic [7:0]            first_byte_d;
    logic                  page_first_d;
    logic                  last_d;

    function automatic logic in_rng(input logic [5:0] v, input logic [5:0] lo, input logic [5:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [7:0] glyph_byte(input logic [6:0] segs, input logic blank,
                                              input logic inv, input logic [1:0] page,
                                              input logic [CW-1:0] col);
        logic [7:0] b;
        logic [6:0] xs;
        logic [5:0] x;
        logic [5:0] row;
        b  = 8'h00;
        xs = {1'b0, 6'(col)} - 7'(SPACE);
        x  = xs[5:0];
        // Negative glyph x (leading spacer column) stays dark; xs[6] is the borrow.
        if (!blank && !xs[6]) begin
            for (int k = 0; k < 8; k++) begin
                row  = {1'b0, page, 3'(k)};
                b[k] = (segs[0] & in_rng(x, 6'd2,  6'd13) & in_rng(row, 6'd0,  6'd4))
                     | (segs[1] & in_rng(x, 6'd12, 6'd15) & in_rng(row, 6'd2,  6'd15))
                     | (segs[2] & in_rng(x, 6'd12, 6'd15) & in_rng(row, 6'd16, 6'd29))
                     | (segs[3] & in_rng(x, 6'd2,  6'd13) & in_rng(row, 6'd27, 6'd31))
                     | (segs[4] & in_rng(x, 6'd0,  6'd3)  & in_rng(row, 6'd16, 6'd29))
                     | (segs[5] & in_rng(x, 6'd0,  6'd3)  & in_rng(row, 6'd2,  6'd15))
                     | (segs[6] & in_rng(x, 6'd2,  6'd13) & in_rng(row, 6'd14, 6'd17));
            end
        end
        return inv ? ~b : b;
    endfunction

    // Next stream position (column innermost) and the byte/flags that go with it.
    always_comb begin
        col_d   = col_q;
        digit_d = digit_q;
        page_d  = page_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            if (digit_q == DIG_LAST) begin
                digit_d = '0;
                page_d  = page_q + 2'd1;
            end else begin
                digit_d = digit_q + DW'(1);
            end
        end else begin
            col_d = col_q + CW'(1);
        end
        byte_d       = glyph_byte(segs_q[7*int'(digit_d) +: 7], blank_q[digit_d], invert_q, page_d, col_d);
        first_byte_d = glyph_byte(segments_in[6:0], blank_in[0], invert_in, 2'd0, '0);
        page_first_d = (digit_d == '0) && (col_d == '0);
        last_d       = (page_d == 2'd3) && (digit_d == DIG_LAST) && (col_d == COL_LAST);
    end

    // Frame FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            page_q       <= 2'd0;
            digit_q      <= '0;
            col_q        <= '0;
            segs_q       <= '0;
            blank_q      <= '0;
            invert_q     <= 1'b0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            page_first_q <= 1'b0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        segs_q       <= segments_in;
                        blank_q      <= blank_in;
                        invert_q     <= invert_in;
                        page_q       <= 2'd0;
                        digit_q      <= '0;
                        col_q        <= '0;
                        out_data_q   <= first_byte_d;
                        out_valid_q  <= 1'b1;
                        page_first_q <= 1'b1;
                        last_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_valid_q && out_ready) begin
                        if (last_q) begin
                            out_valid_q  <= 1'b0;
                            out_data_q   <= 8'h00;
                            page_first_q <= 1'b0;
                            last_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            page_q       <= page_d;
                            digit_q      <= digit_d;
                            col_q        <= col_d;
                            out_data_q   <= byte_d;
                            page_first_q <= page_first_d;
                            last_q       <= last_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    page_q  <= 2'd0;
                    digit_q <= '0;
                    col_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_page_first = page_first_q;
    assign out_last       = last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_seg7_frame_streamer.sv
// Scoreboard bench for seg7_frame_streamer: three configurations share one
// stimulus/monitor path selected by sel.
module tb_seg7_frame_streamer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_drv;
    logic [27:0] seg_drv;
    logic [3:0]  blank_drv;
    logic        inv_drv;
    logic        rdy;
    int          sel;

    logic       st_a, st_b, st_c;
    logic [7:0] a_data, b_data, c_data, m_data;
    logic       a_valid, b_valid, c_valid, m_valid;
    logic       a_pf, b_pf, c_pf, m_pf;
    logic       a_last, b_last, c_last, m_last;
    logic       a_busy, b_busy, c_busy, m_busy;
    logic       a_done, b_done, c_done, m_done;

    assign st_a = start_drv && (sel == 0);
    assign st_b = start_drv && (sel == 1);
    assign st_c = start_drv && (sel == 2);

    seg7_frame_streamer #(.DIGITS(1), .SPACE(2)) u_a (
        .clk(clk), .reset(reset), .start(st_a), .segments_in(seg_drv[6:0]),
        .blank_in(blank_drv[0:0]), .invert_in(inv_drv), .out_data(a_data),
        .out_valid(a_valid), .out_ready(rdy), .out_page_first(a_pf),
        .out_last(a_last), .busy(a_busy), .done(a_done));

    seg7_frame_streamer #(.DIGITS(4), .SPACE(2)) u_b (
        .clk(clk), .reset(reset), .start(st_b), .segments_in(seg_drv),
        .blank_in(blank_drv), .invert_in(inv_drv), .out_data(b_data),
        .out_valid(b_valid), .out_ready(rdy), .out_page_first(b_pf),
        .out_last(b_last), .busy(b_busy), .done(b_done));

    seg7_frame_streamer #(.DIGITS(1), .SPACE(0)) u_c (
        .clk(clk), .reset(reset), .start(st_c), .segments_in(seg_drv[6:0]),
        .blank_in(blank_drv[0:0]), .invert_in(inv_drv), .out_data(c_data),
        .out_valid(c_valid), .out_ready(rdy), .out_page_first(c_pf),
        .out_last(c_last), .busy(c_busy), .done(c_done));

    always_comb begin
        case (sel)
            0:       {m_data, m_valid, m_pf, m_last, m_busy, m_done} = {a_data, a_valid, a_pf, a_last, a_busy, a_done};
            1:       {m_data, m_valid, m_pf, m_last, m_busy, m_done} = {b_data, b_valid, b_pf, b_last, b_busy, b_done};
            default: {m_data, m_valid, m_pf, m_last, m_busy, m_done} = {c_data, c_valid, c_pf, c_last, c_busy, c_done};
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam int ND[3]  = '{1, 4, 1};
    localparam int SP[3]  = '{2, 2, 0};
    // Segment rectangles a..g: glyph x range and row range, inclusive.
    localparam int XLO[7] = '{2, 12, 12, 2, 0, 0, 2};
    localparam int XHI[7] = '{13, 15, 15, 13, 3, 3, 13};
    localparam int RLO[7] = '{0, 2, 16, 27, 16, 2, 14};
    localparam int RHI[7] = '{4, 15, 29, 31, 29, 15, 17};

    function automatic logic [7:0] model_byte(input int page, input int col, input int space,
                                              input logic [6:0] segs, input logic blank, input logic inv);
        logic [7:0] b;
        int x, row;
        b = 8'h00;
        x = col - space;
        if (!blank && x >= 0) begin
            for (int k = 0; k < 8; k++) begin
                row = 8 * page + k;
                for (int s = 0; s < 7; s++)
                    if (segs[s] && x >= XLO[s] && x <= XHI[s] && row >= RLO[s] && row <= RHI[s])
                        b[k] = 1'b1;
            end
        end
        return inv ? ~b : b;
    endfunction

    logic [9:0] exp_q[$];
    logic [7:0] cap[$];
    int         xfers, pf_cnt;

    task automatic run_frame(input int which, input logic [27:0] segs, input logic [3:0] blank,
                             input logic inv, input bit rnd, input int abort_at);
        int nd, sp, cw, len, n;
        logic [9:0] e, held;
        bit stalled, got_last;
        nd = ND[which]; sp = SP[which]; cw = sp + 16; len = 4 * nd * cw;
        exp_q.delete(); cap.delete(); xfers = 0; pf_cnt = 0;
        for (int p = 0; p < 4; p++)
            for (int d = 0; d < nd; d++)
                for (int c = 0; c < cw; c++) begin
                    e = {(d == 0 && c == 0), (p == 3 && d == nd - 1 && c == cw - 1),
                         model_byte(p, c, sp, segs[7*d +: 7], blank[d], inv)};
                    exp_q.push_back(e);
                end
        @(posedge clk); #1;
        sel = which; seg_drv = segs; blank_drv = blank; inv_drv = inv; start_drv = 1'b1;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0; seg_drv = ~segs; blank_drv = ~blank; inv_drv = ~inv;
        @(negedge clk);
        check_val("latency_valid", {31'd0, m_valid}, 32'd1);
        check_val("latency_busy", {31'd0, m_busy}, 32'd1);
        stalled = 1'b0; got_last = 1'b0; held = '0; n = 0;
        while (n < 4000 && !got_last) begin
            if (stalled) begin
                check_val("stall_valid", {31'd0, m_valid}, 32'd1);
                check_val("stall_stable", {22'd0, m_pf, m_last, m_data}, {22'd0, held});
            end
            if (m_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_byte", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val($sformatf("byte%0d", xfers), {22'd0, m_pf, m_last, m_data}, {22'd0, e});
                end
                cap.push_back(m_data);
                xfers++;
                if (m_pf) pf_cnt++;
                if (m_last) got_last = 1'b1;
                stalled = 1'b0;
            end else begin
                stalled = m_valid;
                held = {m_pf, m_last, m_data};
            end
            n++;
            if (abort_at > 0 && xfers == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1; start_drv = 1'b1; seg_drv = segs;
                @(posedge clk); #1;
                reset = 1'b0; start_drv = 1'b0;
                @(negedge clk);
                check_val("abort_valid", {31'd0, m_valid}, 32'd0);
                check_val("abort_busy", {31'd0, m_busy}, 32'd0);
                @(negedge clk);
                check_val("abort_no_start", {30'd0, m_valid, m_busy}, 32'd0);
                return;
            end
            if (!got_last) begin
                @(posedge clk); #1;
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                start_drv = (n == 5);
                seg_drv = 28'($urandom);
                @(negedge clk);
            end
        end
        check_val("no_timeout", {31'd0, got_last}, 32'd1);
        if (!rnd) check_val("cycles", n, len);
        check_val("xfers", xfers, len);
        check_val("queue_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        check_val("done_state", {29'd0, m_done, m_valid, m_busy}, 32'b101);
        @(negedge clk);
        check_val("back_idle", {30'd0, m_done, m_busy}, 32'd0);
    endtask

    int         nz;
    logic [7:0] ev;
    int         idx_t[12] = '{0, 1, 2, 4, 6, 14, 16, 18, 20, 24, 32, 35};
    logic [7:0] val_t[12] = '{8'h00, 8'h00, 8'hFC, 8'hFF, 8'h1F, 8'hFF, 8'hFC,
                              8'h00, 8'hFF, 8'hC0, 8'hFF, 8'hFF};

    initial begin
        reset = 1'b1; start_drv = 1'b0; seg_drv = '0; blank_drv = '0; inv_drv = 1'b0;
        rdy = 1'b0; sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_val($sformatf("reset_state%0d", s), {18'd0, m_data, m_valid, m_pf, m_last, m_busy, m_done}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run_frame(0, 28'h7F, 4'h0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++)
            check_val($sformatf("full_col%0d", idx_t[i]), {24'd0, cap[idx_t[i]]}, {24'd0, val_t[i]});

        run_frame(0, 28'h7F, 4'h0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 12; i++)
            check_val($sformatf("inv_col%0d", idx_t[i]), {24'd0, cap[idx_t[i]]}, {24'd0, ~val_t[i]});

        run_frame(1, 28'($urandom), 4'b0010, 1'b0, 1'b1, 0);
        check_val("page_first_cnt", pf_cnt, 32'd4);
        nz = 0;
        foreach (cap[i]) if (((i / 18) % 4) == 1 && cap[i] != 8'h00) nz++;
        check_val("blank_digit1", nz, 32'd0);

        run_frame(1, 28'h5B_3F_6D7, 4'h0, 1'b0, 1'b0, 10);
        run_frame(1, 28'hFFF_FFFF, 4'h0, 1'b0, 1'b0, 0);
        check_val("restart_first", {24'd0, cap[0]}, 32'h00);

        run_frame(2, 28'h40, 4'h0, 1'b0, 1'b0, 0);
        nz = 0;
        foreach (cap[i]) begin
            ev = 8'h00;
            if ((i % 16) >= 2 && (i % 16) <= 13) begin
                if (i / 16 == 1) ev = 8'hC0;
                if (i / 16 == 2) ev = 8'h03;
            end
            if (cap[i] !== ev) nz++;
        end
        check_val("g_only_bytes", nz, 32'd0);
        check_val("g_only_p1x2", {24'd0, cap[18]}, 32'hC0);
        check_val("g_only_p2x2", {24'd0, cap[34]}, 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_frame_streamer.md
SEG7_FRAME_STREAMER -- requirements
Module: seg7_frame_streamer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of digit cells per frame (legal 1..8).
REQ-002 SHALL have parameter SPACE, default 2, number of blank columns before each glyph (legal 0..7).
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have the port start, input, 1 bit: a frame request, sampled only in IDLE.
REQ-006 SHALL have the port segments_in, input, 7*DIGITS bits: digit d uses bits [7d+6:7d], in order a,b,c,d,e,f,g from bit 0 to bit 6.
REQ-007 SHALL have the port blank_in, input, DIGITS bits: 1 means render digit d as all-off.
REQ-008 SHALL have the port invert_in, input, 1 bit: 1 means invert every output byte.
REQ-009 SHALL have the port out_data, output, 8 bits: one SSD1306 page column, where bit k is row 8*page+k.
REQ-010 SHALL have the port out_valid, output, 1 bit, and the port out_ready, input, 1 bit, forming a valid/ready byte handshake.
REQ-011 SHALL have the port out_page_first, output, 1 bit: asserted with the first byte of each page.
REQ-012 SHALL have the port out_last, output, 1 bit: asserted with the final byte of the frame.
REQ-013 SHALL have the port busy, output, 1 bit, and the port done, output, 1 bit: done is a one-cycle pulse at frame end.

Function
REQ-014 SHALL define CELL_W = SPACE+16 columns per digit and 4 pages (32 rows) per frame, giving a frame length of 4*DIGITS*CELL_W bytes.
REQ-015 SHALL stream bytes in this order: page 0..3 outermost, then digit 0..DIGITS-1, then column 0..CELL_W-1 innermost.
REQ-016 SHALL use glyph column x = column-SPACE; columns below SPACE SHALL be 0x00 before inversion.
REQ-017 SHALL light these segments, with all ranges inclusive: a at x2..13, rows 0..4; b at x12..15, rows 2..15; c at x12..15, rows 16..29; d at x2..13, rows 27..31; e at x0..3, rows 16..29; f at x0..3, rows 2..15; g at x2..13, rows 14..17.
REQ-018 SHALL form each pixel as the bitwise OR of all enabled segments; a blanked digit SHALL yield 0x00; when invert is latched, out_data SHALL be the bitwise NOT of the byte.
REQ-019 SHALL implement the states IDLE, STREAM and DONE.
REQ-020 SHALL, when start=1 in IDLE, latch segments_in, blank_in and invert_in at that edge and move to STREAM; input changes afterwards SHALL NOT affect the frame.
REQ-021 SHALL assert the first out_valid in the cycle after the latching edge, i.e. one cycle of latency.
REQ-022 SHALL transfer a byte on each edge where out_valid=1 and out_ready=1, with at most one byte per cycle; a full-throughput frame SHALL take exactly the frame length in cycles.
REQ-023 SHALL hold out_data, out_page_first and out_last stable while out_valid=1 and out_ready=0; out_valid SHALL NOT drop until the byte is transferred.
REQ-024 SHALL assert out_page_first at page p, digit 0, column 0, and assert out_last at page 3, digit DIGITS-1, column CELL_W-1.
REQ-025 SHALL, on transfer of the last byte, go to DONE with out_valid=0; DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-026 SHALL assert busy=1 in STREAM and DONE and busy=0 in IDLE.
REQ-027 SHALL ignore start when the state is STREAM or DONE; a new frame SHALL begin no earlier than the cycle after done.
REQ-028 SHALL NOT let out_ready affect the outputs while out_valid=0.
REQ-029 SHALL size the counters to hold the maximum values without wrap (page 2 bits, digit clog2(DIGITS), column clog2(CELL_W)); when the column wraps the digit SHALL increment, and when the digit wraps the page SHALL increment.

Reset
REQ-030 SHALL, when reset=1 at an edge, force state IDLE, all counters 0, out_valid=0, out_data=0x00, out_page_first=0, out_last=0, busy=0 and done=0.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no further bytes; start in the same cycle as reset SHALL be ignored.

Verification
REQ-032 SHALL verify: DIGITS=1, SPACE=2, segs=0x7F, invert=0, out_ready=1 -> page 0 bytes: 00,00,FC,FC,FF,FF,1F x8,FF,FF,FC,FC; page 1: 00,00,FF,FF,FF,FF,C0 x8,FF,FF,FF,FF; 72 bytes; out_last on byte 71; done one cycle later.
REQ-033 SHALL verify: same stimulus with invert=1 -> every byte equals the bitwise NOT of the REQ-032 byte (page 0 column 0 = FF).
REQ-034 SHALL verify: DIGITS=4, blank_in=4'b0010, random out_ready -> digit 1 columns all 00; byte stability under stall; 288 transfers; out_page_first exactly 4 times.
REQ-035 SHALL verify: a start pulse during STREAM with changed segments_in -> no restart; frame matches the originally latched values.
REQ-036 SHALL verify: reset asserted after byte 10 -> out_valid=0 and busy=0 the next cycle; a following start produces a full, correct frame from page 0, column 0.
REQ-037 SHALL verify: segs=0x40 (g only), SPACE=0 -> page 1 x2..13 = C0, page 2 x2..13 = 03, all other bytes 00.
